link_control: RTL and testbench
===============================

Name: link_control

Overview:
- Frame-level sequencer that sits directly upstream of the Link character datapath.
- Once per video frame it draws the background map, samples the debounced player buttons, issues exactly one action pulse, then requests the character draw and waits for draw_done.
- All state strobes consumed by the character block (init, idle, attack, move_*, draw_char) originate here.

Parameters:
- MOVE_DIV, 1, frames per 1-pixel movement step; range 1..15.
- ATTACK_FRAMES, 8, frames an attack lasts; movement is locked out for this period; range 1..63.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at frame start
- btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  debounced, active-high buttons
- map_done  in  1  background map draw finished
- draw_done  in  1  character draw finished
- init  out  1  character initialise strobe
- idle  out  1  controller waiting for frame_tick
- attack  out  1  attack action pulse
- move_up, move_down, move_left, move_right  out  1 each  movement pulses
- draw_map  out  1  background draw request (level)
- draw_char  out  1  character draw request (level)
- overrun  out  1  sticky flag: frame_tick arrived while busy

Behaviour:
- Outputs are registered Moore decodes of the state. At most one of init/idle/attack/move_*/draw_map/draw_char is high in any cycle.
- Reset (reset==0 at a clock edge):
  - state becomes S_RESET; all outputs 0; overrun 0; counters 0.
  - Reset mid-operation aborts any draw immediately. draw_map and draw_char drop the next cycle.
- States and transitions:
  - S_RESET: go to S_INIT on the first edge with reset==1.
  - S_INIT: init=1 for exactly 1 cycle, then S_IDLE.
  - S_IDLE: idle=1. On frame_tick go to S_MAP.
  - S_MAP: draw_map=1, held until map_done==1 is sampled, then S_DECIDE.
  - S_DECIDE: 1 cycle, no output high. Chooses the next state as follows:
    - If atk_cnt!=0: decrement atk_cnt and go to S_ATTACK. Movement is ignored.
    - Else if btn_attack: load atk_cnt=ATTACK_FRAMES-1 and go to S_ATTACK.
    - Else if step_ok and a direction button is held: go to S_MOVE. Priority is up > down > left > right. Opposing buttons resolve by this priority.
    - Else go to S_CHAR.
  - S_ATTACK / S_MOVE: the matching strobe is high for exactly 1 cycle, then S_CHAR.
  - S_CHAR: draw_char=1, held until draw_done==1 is sampled, then S_IDLE.
- Move-rate divider:
  - div_cnt counts 0..MOVE_DIV-1 and advances once per S_DECIDE visit, wrapping to 0.
  - step_ok = (div_cnt==0).
  - With MOVE_DIV=1 a move is allowed every frame.
- Frame overrun:
  - A frame_tick seen in any state other than S_IDLE is dropped and sets overrun=1.
  - overrun clears only on reset.
  - A frame_tick in the same cycle that S_CHAR exits counts as an overrun.
- draw_done or map_done asserted outside their wait states is ignored.
- The attack pulse count per attack equals ATTACK_FRAMES, one pulse per frame.

Optional Feature:
- Macro: LINK_BOUNDS_EN.
- When defined:
  - A shadow position is kept: x 8-bit, y 8-bit, reset/init value x=0x7F, y=0x58.
  - The shadow is updated with each move pulse (±1).
  - A move that would leave x∈[0,240] or y∈[0,160] (256x176 map, 16x16 sprite) is suppressed. S_DECIDE goes to S_CHAR instead.
  - Additional outputs: shadow_x[7:0], shadow_y[7:0].
- When not defined: no shadow registers and no bounds checks; those ports are absent.

Decomposition:
- Shared package link_pkg:
  - state enum: S_RESET, S_INIT, S_IDLE, S_MAP, S_DECIDE, S_ATTACK, S_MOVE, S_CHAR
  - direction codes: UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11
  - map size 256x176, sprite size 16, spawn x=0x7F, y=0x58
- Sub-module link_btn_arbiter: combinational priority encoder turning the buttons into a one-hot action. It is shared with future enemy AI.

Test Plan:
- Reset low 3 cycles, then high → all outputs 0 during reset; init=1 on the 1st cycle after; idle=1 from the 2nd cycle.
- frame_tick, map_done after 5 cycles, btn_up=1, draw_done after 64 cycles → move_up pulses 1 cycle after S_DECIDE; draw_char high 64 cycles; then idle.
- btn_attack held 1 frame with ATTACK_FRAMES=8, btn_right held throughout → 8 consecutive frames with an attack pulse and zero move_right; move_right resumes on frame 9.
- MOVE_DIV=3, btn_left held 9 frames → exactly 3 move_left pulses, on frames 1, 4 and 7.
- frame_tick injected during S_CHAR → no extra frame started; overrun=1 stays set until reset.
- LINK_BOUNDS_EN, 8 frames of right moves from x=0xEE → shadow_x stops at 0xF0 (240); no move_right after x reaches 240.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and constants for the Link frame sequencer and its helpers.
// Holds the controller state encoding, movement direction codes, map and
// sprite geometry, the spawn position, and one-hot action bit positions.
package link_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_MAP,
    S_DECIDE,
    S_ATTACK,
    S_MOVE,
    S_CHAR
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  localparam int MAP_W  = 256;
  localparam int MAP_H  = 176;
  localparam int SPRITE = 16;

  localparam logic [7:0] SPAWN_X = 8'h7F;
  localparam logic [7:0] SPAWN_Y = 8'h58;

  // Largest top-left coordinate that keeps the whole sprite on the map.
  localparam logic [7:0] X_MAX = 8'(MAP_W - SPRITE);
  localparam logic [7:0] Y_MAX = 8'(MAP_H - SPRITE);

  // Bit positions in the arbiter's one-hot action vector.
  localparam int ACT_W      = 5;
  localparam int ACT_RIGHT  = 0;
  localparam int ACT_LEFT   = 1;
  localparam int ACT_DOWN   = 2;
  localparam int ACT_UP     = 3;
  localparam int ACT_ATTACK = 4;

  // One-pixel step of a coordinate in either direction.
  function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic inc);
    return inc ? (pos + 8'd1) : (pos - 8'd1);
  endfunction

endpackage

// File: rtl/link_btn_arbiter.sv
// Purpose: priority encoder turning held buttons into one one-hot action.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the consumer samples the action when it needs it.
// Ports: btn_up/btn_down/btn_left/btn_right/btn_attack in (active high),
//        act[ACT_W-1:0] out (one-hot, all-zero when nothing is held),
//        dir out (direction of the selected move, UP when no move selected).
// Priority: attack > up > down > left > right, so opposing buttons resolve
// toward the earlier entry.
import link_pkg::*;

module link_btn_arbiter (
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_attack,
  output logic [ACT_W-1:0] act,
  output dir_t             dir
);

  always_comb begin
    act = '0;
    dir = UP;
    if (btn_attack) begin
      act[ACT_ATTACK] = 1'b1;
    end else if (btn_up) begin
      act[ACT_UP] = 1'b1;
      dir         = UP;
    end else if (btn_down) begin
      act[ACT_DOWN] = 1'b1;
      dir           = DOWN;
    end else if (btn_left) begin
      act[ACT_LEFT] = 1'b1;
      dir           = LEFT;
    end else if (btn_right) begin
      act[ACT_RIGHT] = 1'b1;
      dir            = RIGHT;
    end
  end

endmodule

// File: rtl/link_control.sv
// Purpose: per-frame sequencer: map draw, button decision, one action pulse,
//          character draw, then wait for the next frame_tick.
// Latency: outputs are registered state decodes, valid the cycle the state is entered.
// Backpressure: draw_map/draw_char hold until map_done/draw_done; a frame_tick
//               arriving while busy is dropped and latches the sticky overrun flag.
// Ports: clock, reset (sync, active low), frame_tick, btn_* in;
//        init, idle, attack, move_up/down/left/right, draw_map, draw_char, overrun out;
//        shadow_x[7:0], shadow_y[7:0] out only when LINK_BOUNDS_EN is defined.
// Build option LINK_BOUNDS_EN: track a shadow sprite position and suppress
// moves that would take the sprite off the map.
import link_pkg::*;

module link_control #(
  parameter int MOVE_DIV      = 1,  // frames per 1-pixel step, 1..15
  parameter int ATTACK_FRAMES = 8   // frames per attack, 1..63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       map_done,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       draw_map,
  output logic       draw_char,
  output logic       overrun
`ifdef LINK_BOUNDS_EN
  ,
  output logic [7:0] shadow_x,
  output logic [7:0] shadow_y
`endif
);

  state_t           state;
  state_t           nxt;
  logic [5:0]       atk_cnt;
  logic [3:0]       div_cnt;
  logic             step_ok;
  logic [ACT_W-1:0] arb_act;
  dir_t             arb_dir;
  logic             move_req;
  logic             in_bounds;
  logic             atk_load;
  logic             atk_dec;
  logic             move_go;

  link_btn_arbiter u_arb (
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_attack(btn_attack),
    .act       (arb_act),
    .dir       (arb_dir)
  );

  assign step_ok  = (div_cnt == 4'd0);
  assign move_req = arb_act[ACT_UP] | arb_act[ACT_DOWN] | arb_act[ACT_LEFT] | arb_act[ACT_RIGHT];

`ifdef LINK_BOUNDS_EN
  always_comb begin
    in_bounds = 1'b1;
    case (arb_dir)
      UP:      in_bounds = (shadow_y != 8'd0);
      DOWN:    in_bounds = (shadow_y < Y_MAX);
      LEFT:    in_bounds = (shadow_x != 8'd0);
      RIGHT:   in_bounds = (shadow_x < X_MAX);
      default: in_bounds = 1'b1;
    endcase
  end

  // Shadow moves on the same edge that raises the move pulse.
  always_ff @(posedge clock) begin
    if (!reset || state == S_INIT) begin
      shadow_x <= SPAWN_X;
      shadow_y <= SPAWN_Y;
    end else if (move_go) begin
      case (arb_dir)
        UP:      shadow_y <= step_pos(shadow_y, 1'b0);
        DOWN:    shadow_y <= step_pos(shadow_y, 1'b1);
        LEFT:    shadow_x <= step_pos(shadow_x, 1'b0);
        default: shadow_x <= step_pos(shadow_x, 1'b1);
      endcase
    end
  end
`else
  assign in_bounds = 1'b1;
`endif

  // Next-state selection; the decision strobes let the register block
  // update the counters without repeating the priority chain.
  always_comb begin
    nxt      = state;
    atk_load = 1'b0;
    atk_dec  = 1'b0;
    move_go  = 1'b0;
    case (state)
      S_RESET: nxt = S_INIT;
      S_INIT:  nxt = S_IDLE;
      S_IDLE:  if (frame_tick) nxt = S_MAP;
      S_MAP:   if (map_done) nxt = S_DECIDE;
      S_DECIDE: begin
        if (atk_cnt != 6'd0) begin
          // An attack in progress locks out movement entirely.
          atk_dec = 1'b1;
          nxt     = S_ATTACK;
        end else if (arb_act[ACT_ATTACK]) begin
          atk_load = 1'b1;
          nxt      = S_ATTACK;
        end else if (step_ok && move_req && in_bounds) begin
          move_go = 1'b1;
          nxt     = S_MOVE;
        end else begin
          nxt = S_CHAR;
        end
      end
      S_ATTACK: nxt = S_CHAR;
      S_MOVE:   nxt = S_CHAR;
      S_CHAR:   if (draw_done) nxt = S_IDLE;
      default:  nxt = S_RESET;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the
  // registered state rather than trailing it by a cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_RESET;
      init       <= 1'b0;
      idle       <= 1'b0;
      attack     <= 1'b0;
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      draw_map   <= 1'b0;
      draw_char  <= 1'b0;
      overrun    <= 1'b0;
      atk_cnt    <= 6'd0;
      div_cnt    <= 4'd0;
    end else begin
      state      <= nxt;
      init       <= (nxt == S_INIT);
      idle       <= (nxt == S_IDLE);
      attack     <= (nxt == S_ATTACK);
      move_up    <= move_go && (arb_dir == UP);
      move_down  <= move_go && (arb_dir == DOWN);
      move_left  <= move_go && (arb_dir == LEFT);
      move_right <= move_go && (arb_dir == RIGHT);
      draw_map   <= (nxt == S_MAP);
      draw_char  <= (nxt == S_CHAR);

      // Any tick outside S_IDLE is lost, including one on S_CHAR's exit edge.
      if (frame_tick && state != S_IDLE) overrun <= 1'b1;

      if (atk_load)     atk_cnt <= 6'(ATTACK_FRAMES - 1);
      else if (atk_dec) atk_cnt <= atk_cnt - 6'd1;

      if (state == S_DECIDE)
        div_cnt <= (div_cnt == 4'(MOVE_DIV - 1)) ? 4'd0 : div_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_link_control.sv
// Bench for link_control: dut0 runs MOVE_DIV=1, dut1 runs MOVE_DIV=3.
// Each frame issued pushes its expected action and draw_char length; a
// negedge monitor pops and compares when draw_char rises and falls.
module tb_link_control;

  localparam int C_NONE  = 0;
  localparam int C_ATK   = 1;
  localparam int C_UP    = 2;
  localparam int C_DOWN  = 3;
  localparam int C_LEFT  = 4;
  localparam int C_RIGHT = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [1:0] ft, bu, bd, bl, br, ba, mdone, ddone;
  logic [1:0] o_init, o_idle, o_atk, o_mu, o_md, o_ml, o_mr, o_dmap, o_dchar, o_ovr;
`ifdef LINK_BOUNDS_EN
  logic [7:0] sx0, sy0, sx1, sy1;
`endif

  int errors = 0;
  int checks = 0;
  int map_lat = 5;
  int char_lat = 64;

  int eq0[$], eq1[$], lq0[$], lq1[$];

  link_control #(.MOVE_DIV(1), .ATTACK_FRAMES(8)) dut0 (
    .clock(clock), .reset(reset), .frame_tick(ft[0]),
    .btn_up(bu[0]), .btn_down(bd[0]), .btn_left(bl[0]), .btn_right(br[0]), .btn_attack(ba[0]),
    .map_done(mdone[0]), .draw_done(ddone[0]),
    .init(o_init[0]), .idle(o_idle[0]), .attack(o_atk[0]),
    .move_up(o_mu[0]), .move_down(o_md[0]), .move_left(o_ml[0]), .move_right(o_mr[0]),
    .draw_map(o_dmap[0]), .draw_char(o_dchar[0]), .overrun(o_ovr[0])
`ifdef LINK_BOUNDS_EN
    , .shadow_x(sx0), .shadow_y(sy0)
`endif
  );

  link_control #(.MOVE_DIV(3), .ATTACK_FRAMES(8)) dut1 (
    .clock(clock), .reset(reset), .frame_tick(ft[1]),
    .btn_up(bu[1]), .btn_down(bd[1]), .btn_left(bl[1]), .btn_right(br[1]), .btn_attack(ba[1]),
    .map_done(mdone[1]), .draw_done(ddone[1]),
    .init(o_init[1]), .idle(o_idle[1]), .attack(o_atk[1]),
    .move_up(o_mu[1]), .move_down(o_md[1]), .move_left(o_ml[1]), .move_right(o_mr[1]),
    .draw_map(o_dmap[1]), .draw_char(o_dchar[1]), .overrun(o_ovr[1])
`ifdef LINK_BOUNDS_EN
    , .shadow_x(sx1), .shadow_y(sy1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int code_of(input int g);
    if (o_atk[g]) return C_ATK;
    if (o_mu[g])  return C_UP;
    if (o_md[g])  return C_DOWN;
    if (o_ml[g])  return C_LEFT;
    if (o_mr[g])  return C_RIGHT;
    return C_NONE;
  endfunction

  // Memory-side responders: map_done/draw_done on the map_lat-th / char_lat-th request cycle.
  int mc[2], dc[2];
  initial begin
    mdone = '0;
    ddone = '0;
    mc[0] = 0; mc[1] = 0; dc[0] = 0; dc[1] = 0;
    forever begin
      step();
      for (int g = 0; g < 2; g++) begin
        mc[g] = o_dmap[g]  ? mc[g] + 1 : 0;
        dc[g] = o_dchar[g] ? dc[g] + 1 : 0;
        mdone[g] = o_dmap[g]  && (mc[g] == map_lat);
        ddone[g] = o_dchar[g] && (dc[g] == char_lat);
      end
    end
  end

  // Monitor
  logic [1:0] pchar = '0;
  int pcode[2];
  int run[2];
  int cur;
  int ones;
  initial begin
    pcode[0] = 0; pcode[1] = 0; run[0] = 0; run[1] = 0;
  end

  always @(negedge clock) begin
    for (int g = 0; g < 2; g++) begin
      cur  = code_of(g);
      ones = $countones({o_init[g], o_idle[g], o_atk[g], o_mu[g], o_md[g], o_ml[g],
                         o_mr[g], o_dmap[g], o_dchar[g]});
      chk("onehot", int'(ones > 1), 0);
      if (cur != C_NONE) chk("pulse_width", pcode[g], C_NONE);
      if (o_dchar[g] && !pchar[g]) begin
        if (g == 0) begin
          if (eq0.size() == 0) chk("unexpected_frame0", 1, 0);
          else chk("action0", pcode[g], eq0.pop_front());
        end else begin
          if (eq1.size() == 0) chk("unexpected_frame1", 1, 0);
          else chk("action1", pcode[g], eq1.pop_front());
        end
      end
      if (!o_dchar[g] && pchar[g]) begin
        if (g == 0) begin
          if (lq0.size() == 0) chk("unexpected_char0", 1, 0);
          else chk("char_len0", run[g], lq0.pop_front());
        end else begin
          if (lq1.size() == 0) chk("unexpected_char1", 1, 0);
          else chk("char_len1", run[g], lq1.pop_front());
        end
      end
      run[g]   = o_dchar[g] ? run[g] + 1 : 0;
      pchar[g] = o_dchar[g];
      pcode[g] = cur;
    end
  end

  task automatic expect_frame(input int g, input int code);
    if (g == 0) begin
      eq0.push_back(code);
      lq0.push_back(char_lat);
    end else begin
      eq1.push_back(code);
      lq1.push_back(char_lat);
    end
  endtask

  task automatic wait_idle(input int g);
    int t;
    t = 0;
    while (!o_idle[g] && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_frame(input int g, input int code);
    expect_frame(g, code);
    wait_idle(g);
    ft[g] = 1'b1;
    step();
    ft[g] = 1'b0;
    wait_idle(g);
  endtask

  // Frame with a second tick injected `offset` cycles into the draw_char phase.
  task automatic overrun_frame(input int g, input int offset);
    int t;
    int idle_cnt;
    expect_frame(g, C_NONE);
    wait_idle(g);
    ft[g] = 1'b1;
    step();
    ft[g] = 1'b0;
    t = 0;
    while (!o_dchar[g] && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) chk("char_timeout", 0, 1);
    repeat (offset - 1) step();
    ft[g] = 1'b1;
    step();
    ft[g] = 1'b0;
    wait_idle(g);
    idle_cnt = 0;
    repeat (10) begin
      step();
      if (o_idle[g]) idle_cnt++;
    end
    chk("no_extra_frame", idle_cnt, 10);
    chk("overrun_set", o_ovr[g], 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) step();
    chk("reset_outputs", int'({o_init, o_idle, o_atk, o_mu, o_md, o_ml, o_mr, o_dmap, o_dchar, o_ovr}), 0);
    reset = 1'b1;
    step();
    chk("init_first", o_init, 3);
    chk("idle_not_yet", o_idle, 0);
    step();
    chk("idle_second", o_idle, 3);
    chk("init_dropped", o_init, 0);
  endtask

  initial begin
    reset = 1'b0;
    ft = '0; bu = '0; bd = '0; bl = '0; br = '0; ba = '0;

    do_reset();
    chk("overrun_after_reset", o_ovr, 0);

    // Single up move with a long character draw.
    map_lat = 5; char_lat = 64;
    bu[0] = 1'b1;
    run_frame(0, C_UP);
    bu[0] = 1'b0;

    // Opposing / multiple buttons resolve by priority.
    map_lat = 1; char_lat = 2;
    bu[0] = 1'b1; bd[0] = 1'b1;
    run_frame(0, C_UP);
    bu[0] = 1'b0;
    run_frame(0, C_DOWN);
    bd[0] = 1'b0; bl[0] = 1'b1; br[0] = 1'b1;
    run_frame(0, C_LEFT);
    bl[0] = 1'b0; br[0] = 1'b0;
    run_frame(0, C_NONE);

    // Attack lasts 8 frames and locks out the held right button.
    map_lat = 3; char_lat = 3;
    ba[0] = 1'b1; br[0] = 1'b1;
    run_frame(0, C_ATK);
    ba[0] = 1'b0;
    for (int i = 1; i < 8; i++) run_frame(0, C_ATK);
    run_frame(0, C_RIGHT);
    run_frame(0, C_RIGHT);
    br[0] = 1'b0;

    // MOVE_DIV=3: left held 9 frames moves on frames 1, 4 and 7.
    bl[1] = 1'b1;
    for (int i = 0; i < 9; i++) run_frame(1, (i % 3 == 0) ? C_LEFT : C_NONE);
    bl[1] = 1'b0;

    // Overrun: tick mid-draw on dut0, tick on the draw_char exit cycle on dut1.
    chk("overrun_clear_before", o_ovr, 0);
    char_lat = 20;
    overrun_frame(0, 3);
    overrun_frame(1, 20);
    map_lat = 2; char_lat = 4;
    run_frame(0, C_NONE);
    run_frame(1, C_NONE);
    chk("overrun_sticky", o_ovr, 3);
    do_reset();
    chk("overrun_cleared", o_ovr, 0);

`ifdef LINK_BOUNDS_EN
    chk("spawn_x", sx0, 8'h7F);
    map_lat = 1; char_lat = 1;
    br[0] = 1'b1;
    for (int i = 0; i < 111; i++) run_frame(0, C_RIGHT);
    chk("shadow_x_pre", sx0, 8'hEE);
    for (int i = 0; i < 8; i++) run_frame(0, (i < 2) ? C_RIGHT : C_NONE);
    br[0] = 1'b0;
    chk("shadow_x_clamp", sx0, 240);
    chk("shadow_y_hold", sy0, 8'h58);
    chk("dut1_shadow_x", sx1, 8'h7F);
    chk("dut1_shadow_y", sy1, 8'h58);
`endif

    repeat (5) step();
    chk("pending_actions", eq0.size() + eq1.size(), 0);
    chk("pending_lengths", lq0.size() + lq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
